// File: rtl/imm_pack_if.sv
// imm_pack_if: input and output valid/ready channels of the immediate packer.
// Ports: in_valid/in_ready/ImmSrc/Value/BaseInstr (request), out_valid/out_ready/Instr/Fault (result).
// master = producer/consumer side, slave = the packer itself.
interface imm_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ImmSrc;
   logic [47:0] Value;
   logic [23:0] BaseInstr;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] Instr;
   logic        Fault;

   modport master (
      output in_valid, ImmSrc, Value, BaseInstr, out_ready,
      input  in_ready, out_valid, Instr, Fault
   );

   modport slave (
      input  in_valid, ImmSrc, Value, BaseInstr, out_ready,
      output in_ready, out_valid, Instr, Fault
   );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: range-checks a 48-bit immediate against ImmSrc and merges the encoded field into BaseInstr.
// Latency 2 edges (S1 encode register, S2 output register); one transaction per cycle when unstalled.
// Backpressure: S1+S2 absorb two transactions while out_ready is low, then in_ready drops.
// Ports: clk, reset (async, active-high), bus (imm_pack_if.slave), ClrCount (sync clear),
//        FaultCount (saturating count of delivered faulting transactions).
module imm_pack (
   input  logic       clk,
   input  logic       reset,
   imm_pack_if.slave  bus,
   input  logic       ClrCount,
   output logic [7:0] FaultCount
);

   logic        s1_valid;
   logic [23:0] s1_instr;
   logic        s1_fault;
   logic        s2_valid;
   logic [23:0] s2_instr;
   logic        s2_fault;
   logic        s2_adv;
   logic [23:0] enc_instr;
   logic        enc_fault;

   // S2 can take new data when empty or being drained this cycle.
   assign s2_adv       = !s2_valid || bus.out_ready;
   // Depends only on state and out_ready, never on in_valid.
   assign bus.in_ready = !s1_valid || s2_adv;

   assign bus.out_valid = s2_valid;
   assign bus.Instr     = s2_instr;
   assign bus.Fault     = s2_fault;

   // Encoder: faulting values leave BaseInstr untouched.
   always_comb begin
      enc_instr = bus.BaseInstr;
      enc_fault = 1'b1;
      case (bus.ImmSrc)
         2'b00: begin
            if (bus.Value[47:8] == '0) begin
               enc_fault = 1'b0;
               enc_instr = {bus.BaseInstr[23:8], bus.Value[7:0]};
            end
         end
         2'b01: begin
            if (bus.Value[47:12] == '0) begin
               enc_fault = 1'b0;
               enc_instr = {bus.BaseInstr[23:12], bus.Value[11:0]};
            end
         end
         2'b10: begin
            // Word aligned and bits 47:25 a pure sign extension of bit 25,
            // so the extender's sign-extend of Instr[23] recreates them.
            if ((bus.Value[1:0] == 2'b00) &&
                ((&bus.Value[47:25]) || (bus.Value[47:25] == '0))) begin
               enc_fault = 1'b0;
               enc_instr = bus.Value[25:2];
            end
         end
         default: begin
            enc_fault = 1'b1;
            enc_instr = bus.BaseInstr;
         end
      endcase
   end

   // Stage 1: load on accept, otherwise empty when it moves on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_instr <= '0;
         s1_fault <= 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
         s1_valid <= 1'b1;
         s1_instr <= enc_instr;
         s1_fault <= enc_fault;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: data only changes when it may advance, which keeps Instr/Fault
   // stable during a stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
         s2_fault <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr <= s1_instr;
            s2_fault <= s1_fault;
         end
      end
   end

   // Fault counter: clear has priority over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         FaultCount <= '0;
      end else if (ClrCount) begin
         FaultCount <= '0;
      end else if (s2_valid && bus.out_ready && s2_fault && (FaultCount != 8'hFF)) begin
         FaultCount <= FaultCount + 8'd1;
      end
   end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: table vectors, hand sequences for stall/saturation/reset, and a random
// scoreboard run against an arithmetic reference model of the packer.
module tb_imm_pack;

   logic       clk = 1'b0;
   logic       reset;
   logic       ClrCount;
   logic [7:0] FaultCount;

   imm_pack_if bus ();

   imm_pack dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .ClrCount   (ClrCount),
      .FaultCount (FaultCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] instr;
      logic        fault;
      logic [1:0]  src;
      logic [47:0] value;
   } txn_t;

   typedef struct {
      logic [1:0]  src;
      logic [47:0] value;
      logic [23:0] base;
      logic [23:0] exp_instr;
      logic        exp_fault;
   } vec_t;

   localparam longint LIM = 64'sd33554432; // 2**25

   txn_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          fc = 0;
   int          n_acc = 0;
   bit          acc = 0;
   bit          stall = 0;
   logic [23:0] hold_i;
   logic        hold_f;

   task automatic check(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   // Reference: representability by plain integer ranges.
   function automatic txn_t model(logic [1:0] s, logic [47:0] v, logic [23:0] b);
      txn_t t;
      longint unsigned uv;
      longint sv;
      uv = {16'd0, v};
      sv = $signed({{16{v[47]}}, v});
      t.src = s; t.value = v; t.fault = 1'b1; t.instr = b;
      case (s)
         2'd0: if (uv < 256)  begin t.fault = 1'b0; t.instr = 24'((longint'(b) / 256) * 256 + longint'(uv)); end
         2'd1: if (uv < 4096) begin t.fault = 1'b0; t.instr = 24'((longint'(b) / 4096) * 4096 + longint'(uv)); end
         2'd2: if ((sv % 4 == 0) && (sv >= -LIM) && (sv < LIM)) begin t.fault = 1'b0; t.instr = 24'(sv / 4); end
         default: t.fault = 1'b1;
      endcase
      return t;
   endfunction

   // Immediate extender, used for the round-trip check.
   function automatic logic [47:0] ext(logic [23:0] i, logic [1:0] s);
      case (s)
         2'd0:    return {40'd0, i[7:0]};
         2'd1:    return {36'd0, i[11:0]};
         default: return {{22{i[23]}}, i, 2'b00};
      endcase
   endfunction

   // Evaluate handshakes for the currently driven inputs, then move to the next negedge.
   task automatic step();
      txn_t e;
      bit   pop_fault;
      #1;
      acc = 0;
      pop_fault = 0;
      if (stall) begin
         check("hold_valid", 64'(bus.out_valid), 64'(1));
         check("hold_instr", 64'(bus.Instr), 64'(hold_i));
         check("hold_fault", 64'(bus.Fault), 64'(hold_f));
      end
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got instr 0x%0h expected no output", bus.Instr);
         end else begin
            e = sb.pop_front();
            check("out_instr", 64'(bus.Instr), 64'(e.instr));
            check("out_fault", 64'(bus.Fault), 64'(e.fault));
            if (!e.fault) check("round_trip", 64'(ext(bus.Instr, e.src)), 64'(e.value));
            pop_fault = e.fault;
         end
      end
      if (ClrCount) fc = 0;
      else if (pop_fault && fc < 255) fc++;
      if (bus.in_valid && bus.in_ready) begin
         sb.push_back(model(bus.ImmSrc, bus.Value, bus.BaseInstr));
         acc = 1;
         n_acc++;
      end
      stall  = bus.out_valid && !bus.out_ready;
      hold_i = bus.Instr;
      hold_f = bus.Fault;
      @(negedge clk);
      check("fault_count", 64'(FaultCount), 64'(fc));
   endtask

   task automatic drain(string n);
      int c;
      c = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && c < 50) begin
         step();
         c++;
      end
      check(n, 64'(sb.size()), 64'(0));
   endtask

   task automatic gen();
      logic [26:0] r27;
      logic [25:0] r26;
      logic [63:0] r64;
      bus.ImmSrc    = 2'($urandom_range(0, 2));
      bus.BaseInstr = 24'($urandom);
      case ($urandom_range(0, 4))
         0: bus.Value = 48'($urandom_range(0, 300));
         1: bus.Value = 48'($urandom_range(0, 5000));
         2: begin r27 = 27'($urandom); bus.Value = {{21{r27[26]}}, r27}; end
         3: begin r64 = {$urandom, $urandom}; bus.Value = r64[47:0]; end
         default: begin r26 = 26'($urandom); bus.Value = {{20{r26[25]}}, r26, 2'b00}; end
      endcase
   endtask

   vec_t vecs[10];

   initial begin
      int c, got, sent;

      vecs[0] = '{2'b00, 48'h1F4,          24'hABCDEF, 24'hABCDEF, 1'b1};
      vecs[1] = '{2'b01, 48'h1F4,          24'hABCDEF, 24'hABC1F4, 1'b0};
      vecs[2] = '{2'b10, 48'hFFFF_FFFF_FFFC, 24'h000000, 24'hFFFFFF, 1'b0};
      vecs[3] = '{2'b10, 48'h0000_01FF_FFFC, 24'h000000, 24'h7FFFFF, 1'b0};
      vecs[4] = '{2'b10, 48'h0000_0200_0000, 24'h123456, 24'h123456, 1'b1};
      vecs[5] = '{2'b10, 48'h6,            24'h654321, 24'h654321, 1'b1};
      vecs[6] = '{2'b11, 48'h0,            24'h0A0B0C, 24'h0A0B0C, 1'b1};
      vecs[7] = '{2'b00, 48'hFF,           24'h111111, 24'h1111FF, 1'b0};
      vecs[8] = '{2'b01, 48'h1000,         24'h222222, 24'h222222, 1'b1};
      vecs[9] = '{2'b10, 48'hFFFF_FE00_0000, 24'h333333, 24'h800000, 1'b0};

      reset = 1'b1; ClrCount = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.ImmSrc = 2'b00; bus.Value = '0; bus.BaseInstr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid",  64'(bus.out_valid), 64'(0));
      check("rst_instr",      64'(bus.Instr), 64'(0));
      check("rst_fault",      64'(bus.Fault), 64'(0));
      check("rst_fault_count", 64'(FaultCount), 64'(0));
      check("rst_in_ready",   64'(bus.in_ready), 64'(1));

      // Table vectors, one isolated transaction each, with latency checks.
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1; bus.ImmSrc = vecs[i].src;
         bus.Value = vecs[i].value; bus.BaseInstr = vecs[i].base;
         check("vec_in_ready", 64'(bus.in_ready), 64'(1));
         step();
         bus.in_valid = 1'b0;
         check("vec_lat_s1", 64'(bus.out_valid), 64'(0));
         step();
         check("vec_out_valid", 64'(bus.out_valid), 64'(1));
         check("vec_instr", 64'(bus.Instr), 64'(vecs[i].exp_instr));
         check("vec_fault", 64'(bus.Fault), 64'(vecs[i].exp_fault));
         step();
      end
      drain("vec_drain");

      // Backpressure: four offered, two absorbed, then release.
      bus.out_ready = 1'b0;
      got = n_acc;
      sent = 0;
      bus.in_valid = 1'b1; bus.ImmSrc = 2'b01; bus.BaseInstr = 24'hC0FFEE; bus.Value = 48'h100;
      for (int k = 0; k < 6; k++) begin
         step();
         if (acc) begin
            sent++;
            bus.Value = (sent == 1) ? 48'h2000 : 48'(48'h100 * (sent + 1));
            if (sent == 4) bus.in_valid = 1'b0;
         end
      end
      check("bp_accepted", 64'(n_acc - got), 64'(2));
      check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      bus.out_ready = 1'b1;
      #1;
      check("bp_in_ready_release", 64'(bus.in_ready), 64'(1));
      c = 0;
      while (sent < 4 && c < 20) begin
         step();
         if (acc) begin
            sent++;
            bus.Value = 48'(48'h100 * (sent + 1));
            if (sent == 4) bus.in_valid = 1'b0;
         end
         c++;
      end
      check("bp_all_sent", 64'(sent), 64'(4));
      drain("bp_drain");

      // Saturation: 260 back-to-back faults, full throughput expected.
      bus.in_valid = 1'b1; bus.ImmSrc = 2'b11; bus.Value = 48'h5; bus.BaseInstr = 24'h0F0F0F;
      sent = 0; c = 0;
      while (sent < 260 && c < 1000) begin
         step();
         if (acc) sent++;
         if (sent == 260) bus.in_valid = 1'b0;
         c++;
      end
      check("sat_throughput", 64'(c), 64'(260));
      drain("sat_drain");
      check("sat_count", 64'(FaultCount), 64'(255));

      // Clear coincident with a faulting output handshake.
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check("clr_out_valid", 64'(bus.out_valid), 64'(1));
      ClrCount = 1'b1;
      step();
      ClrCount = 1'b0;
      check("clr_wins", 64'(FaultCount), 64'(0));

      // Reset with both stages full.
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      drain("pre_rst_drain");
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      got = 0; c = 0;
      while (got < 2 && c < 10) begin
         step();
         if (acc) got++;
         c++;
      end
      bus.in_valid = 1'b0;
      check("rst_fill", 64'(got), 64'(2));
      check("rst_full_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_full_count", 64'(FaultCount), 64'(1));
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'(0));
      check("arst_fault_count", 64'(FaultCount), 64'(0));
      check("arst_in_ready", 64'(bus.in_ready), 64'(1));
      sb.delete(); fc = 0; stall = 0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
      bus.in_valid = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 48'h5A; bus.BaseInstr = 24'h123400;
      step();
      bus.in_valid = 1'b0;
      check("post_rst_lat_s1", 64'(bus.out_valid), 64'(0));
      step();
      check("post_rst_valid", 64'(bus.out_valid), 64'(1));
      check("post_rst_instr", 64'(bus.Instr), 64'(24'h12345A));
      drain("post_rst_drain");

      // Random scoreboard run with random backpressure.
      sent = 0; c = 0; acc = 0;
      while (sent < 10000 && c < 40000) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!bus.in_valid || acc) begin
            if ($urandom_range(0, 4) != 0) begin
               bus.in_valid = 1'b1;
               gen();
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         step();
         if (acc) begin
            sent++;
            if (sent == 10000) bus.in_valid = 1'b0;
         end
         c++;
      end
      check("rand_sent", 64'(sent), 64'(10000));
      drain("rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
